// File: rtl/rr_arb_sel.sv
// rr_arb_sel: round-robin arbiter producing a registered one-hot mux select
// plus the binary index of the winner, held under a valid/ack handshake.
// Optional checks: define RR_ARB_SEL_SVA_EN to compile in assertions.
module rr_arb_sel #(
   parameter  int unsigned N = 4,
   localparam int unsigned W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] i_req,
   input  logic         i_ack,
   output logic         o_vld,
   output logic [N-1:0] o_sel,
   output logic [W-1:0] o_idx
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   localparam logic [W:0]   N_EXT = (W+1)'(N);
   localparam logic [W-1:0] LAST  = W'(N - 1);

   logic [0:0]   state_q;
   logic [0:0]   state_nxt;
   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_nxt;
   logic         vld_nxt;
   logic [N-1:0] sel_nxt;
   logic [W-1:0] idx_nxt;

   logic [W-1:0] ack_ptr_c;
   logic [W-1:0] base_c;
   logic [W:0]   cand_c;
   logic         win_vld_c;
   logic [W-1:0] win_idx_c;
   logic [N-1:0] win_sel_c;

   // Pointer after an ack of the current grant (modulo N, any N).
   always_comb begin
      ack_ptr_c = (o_idx == LAST) ? '0 : o_idx + W'(1);
      base_c    = (state_q == GRANT) ? ack_ptr_c : ptr_q;
   end

   // Scan requests upward from base_c with wrap-around; first set bit wins.
   always_comb begin
      win_vld_c = 1'b0;
      win_idx_c = '0;
      cand_c    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand_c = {1'b0, base_c} + (W+1)'(i);
         if (cand_c >= N_EXT) cand_c = cand_c - N_EXT;
         if (!win_vld_c && i_req[cand_c[W-1:0]]) begin
            win_vld_c = 1'b1;
            win_idx_c = cand_c[W-1:0];
         end
      end
      win_sel_c = N'(1) << win_idx_c;
   end

   // Next-state and next-output decode; grant is frozen until acked.
   always_comb begin
      state_nxt = state_q;
      ptr_nxt   = ptr_q;
      vld_nxt   = o_vld;
      sel_nxt   = o_sel;
      idx_nxt   = o_idx;
      case (state_q)
         IDLE: begin
            if (win_vld_c) begin
               vld_nxt   = 1'b1;
               sel_nxt   = win_sel_c;
               idx_nxt   = win_idx_c;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (i_ack) begin
               ptr_nxt = ack_ptr_c;
               if (win_vld_c) begin
                  sel_nxt = win_sel_c;
                  idx_nxt = win_idx_c;
               end else begin
                  vld_nxt   = 1'b0;
                  sel_nxt   = '0;
                  idx_nxt   = '0;
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            vld_nxt   = 1'b0;
            sel_nxt   = '0;
            idx_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // State, pointer and registered outputs; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         o_vld   <= 1'b0;
         o_sel   <= '0;
         o_idx   <= '0;
      end else begin
         state_q <= state_nxt;
         ptr_q   <= ptr_nxt;
         o_vld   <= vld_nxt;
         o_sel   <= sel_nxt;
         o_idx   <= idx_nxt;
      end
   end

`ifdef RR_ARB_SEL_SVA_EN
   int unsigned wait_cnt [N];

   // Count completed grants to others while a requestor keeps waiting.
   always_ff @(posedge clk) begin
      for (int r = 0; r < N; r++) begin
         if (rst || !i_req[r] || (o_vld && i_ack && o_idx == W'(r)))
            wait_cnt[r] <= 0;
         else if (o_vld && i_ack)
            wait_cnt[r] <= wait_cnt[r] + 1;
      end
   end

   // A waiting requestor is served before N other grants complete.
   always @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < N; r++)
            a_fair: assert (wait_cnt[r] < N);
      end
   end

   a_onehot0: assert property (@(posedge clk) $onehot0(o_sel));
   a_vld_sel: assert property (@(posedge clk) o_vld == |o_sel);
   a_idx_sel: assert property (@(posedge clk) o_vld |-> o_sel[o_idx]);
   a_hold:    assert property (@(posedge clk) disable iff (rst)
                 (o_vld && !i_ack) |=> ($stable(o_sel) && $stable(o_idx)));
`else
`endif

endmodule

// File: tb/tb_rr_arb_sel.sv
// tb_rr_arb_sel: directed vectors for rr_arb_sel (N=4); driver queues the
// expected registered outputs, monitor pops and compares each cycle.
module tb_rr_arb_sel;

   localparam int unsigned N = 4;
   localparam int unsigned W = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic         ack;
   logic         vld;
   logic [N-1:0] sel;
   logic [W-1:0] idx;

   typedef struct {
      string        name;
      logic         vld;
      logic [N-1:0] sel;
      logic [W-1:0] idx;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   rr_arb_sel #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .i_req (req),
      .i_ack (ack),
      .o_vld (vld),
      .o_sel (sel),
      .o_idx (idx)
   );

   always #5 clk = ~clk;

   // Monitor: outputs are stable at the falling edge; compare against queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (vld !== e.vld || sel !== e.sel || idx !== e.idx) begin
               bad++;
               $display("FAIL %s: got vld=%0b sel=%b idx=%0d, want vld=%0b sel=%b idx=%0d",
                        e.name, vld, sel, idx, e.vld, e.sel, e.idx);
            end
         end
      end
   end

   // Drive one cycle of inputs and queue the outputs expected after the edge.
   task automatic step(input string nm, input logic r, input logic [N-1:0] rq,
                       input logic a, input logic ev, input logic [N-1:0] es,
                       input logic [W-1:0] ei);
      exp_t e;
      rst = r;
      req = rq;
      ack = a;
      @(posedge clk);
      e.name = nm;
      e.vld  = ev;
      e.sel  = es;
      e.idx  = ei;
      q.push_back(e);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      ack = 1'b0;
      @(negedge clk);
      //     name          rst  req      ack   vld  sel      idx
      step("reset0",       1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0);
      step("reset1",       1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0);
      step("first_grant",  1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0);
      step("ack_to_idle",  1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
      // ptr=1: lone request on 2, then frozen for four cycles without ack
      step("hold_grant",   1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2);
      for (int i = 0; i < 4; i++)
         step("hold_frozen", 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0100, 2'd2);
      step("hold_release", 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
      // ptr=3: first grant goes to 3, then rotation 0,1,2,3,0 with no bubble
      step("fair_start",   1'b0, 4'b1111, 1'b0, 1'b1, 4'b1000, 2'd3);
      step("fair_0",       1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0);
      step("fair_1",       1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1);
      step("fair_2",       1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2);
      step("fair_3",       1'b0, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3);
      step("fair_wrap",    1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0);
      // grant to 2, ack it with 0101 pending: scan 3 then wraps to 0
      step("skip_to_2",    1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2);
      step("skip_wrap0",   1'b0, 4'b0101, 1'b1, 1'b1, 4'b0001, 2'd0);
      step("skip_back2",   1'b0, 4'b0101, 1'b1, 1'b1, 4'b0100, 2'd2);
      step("skip_idle",    1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
      // sole requester 1 re-granted every cycle while acked
      step("sole_first",   1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1);
      for (int i = 0; i < 3; i++)
         step("sole_again", 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1);
      step("sole_idle",    1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
      // ack while idle must not move ptr (still 2)
      step("idle_ack",     1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
      step("idle_ack_ptr", 1'b0, 4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2);
      // grant to 3, then reset mid-grant restores ptr to 0
      step("pre_rst_g3",   1'b0, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3);
      step("mid_reset",    1'b1, 4'b1001, 1'b0, 1'b0, 4'b0000, 2'd0);
      step("post_reset",   1'b0, 4'b1001, 1'b0, 1'b1, 4'b0001, 2'd0);
      step("final_idle",   1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);

      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_arb_sel.md
# rr_arb_sel

Round-robin arbiter that turns N request lines into a registered one-hot select for the downstream datapath mux, together with the index of the winner. It sits directly upstream of the select port of a mux stage. Its `o_sel` output must always be one-hot or all-zero, which is the legality rule that mux select ports check. Each grant is held stable under a valid/ack handshake until the consumer accepts it.

## Interface
- `N`, default 4, number of requestors; legal range 2..32.
- `W`, default `$clog2(N)`, width of `o_idx`; derived, not overridden.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_req`  in  N  per-requestor request level.
- `i_ack`  in  1  consumer accepts current grant; meaningful only while `o_vld`.
- `o_vld`  out  1  a grant is presented.
- `o_sel`  out  N  one-hot grant vector; all-zero when `!o_vld`.
- `o_idx`  out  W  binary index of the set bit of `o_sel`; 0 when `!o_vld`.

## Operation
- State: `IDLE` (no grant) and `GRANT` (grant held), plus a priority pointer `ptr` in the range 0..N-1.
- Arbitration: scan `i_req` starting at `ptr` and moving upward with wrap-around. The first set bit wins.
- `IDLE`:
  - If `|i_req`, register the winner into `o_sel`/`o_idx`, set `o_vld`, and go to `GRANT`.
  - Otherwise stay in `IDLE`.
- `GRANT`:
  - `o_sel`, `o_idx` and `o_vld` are frozen while `!i_ack`, regardless of `i_req`. A requester dropping its request does not revoke the grant.
  - On `i_ack`, set `ptr <= (o_idx + 1) mod N`.
  - In the same cycle, arbitrate `i_req` using that new pointer value (computed combinationally, not the registered `ptr`).
  - If any request is set, load the new winner and stay in `GRANT` (back-to-back). Otherwise clear the outputs and go to `IDLE`.
- The acked requester can win again immediately only if no other request is set.
- `ptr` changes only on an ack; it does not change on a grant alone.
- Pointer wrap: with `o_idx == N-1`, an ack sets `ptr` to 0. The index arithmetic is modulo N and also correct for non-power-of-2 N.
- `o_sel` is always onehot0, and `o_idx` always matches it.

## Timing
- Reset values: `o_vld=0`, `o_sel=0`, `o_idx=0`, `ptr=0`, state `IDLE`.
- `rst` takes priority over every other event. When asserted mid-grant, all outputs return to reset values on the next edge and the pending grant is dropped without an ack.
- Request-to-grant latency: `i_req` seen at edge t in `IDLE` gives `o_vld=1` after edge t.
- Ack-to-next-grant: zero bubble. With `i_ack=1` at edge t and requests pending, the new grant is valid in the cycle after edge t.
- Sustained throughput: one grant per cycle when `i_ack` is held high and requests are pending.
- `i_ack` while `!o_vld` is ignored.
- Outputs are purely registered; there is no combinational path from `i_req` or `i_ack` to any output.

## Configuration
- `RR_ARB_SEL_SVA_EN`: when defined, the block compiles in immediate/concurrent assertions:
  - `o_sel` is onehot0;
  - `o_vld == |o_sel`;
  - `o_sel[o_idx]` is set when `o_vld`;
  - `o_sel`/`o_idx` are stable across a cycle with `o_vld && !i_ack`;
  - no requestor waits more than N grants while holding `i_req`.
- When undefined, no checking logic is present and RTL function is identical.

## Test plan
- Reset: with `rst=1` for 2 cycles and `i_req=4'b1111`, outputs read `o_vld=0`, `o_sel=4'b0000`, `o_idx=0`. After `rst` deasserts, the first grant is `o_sel=4'b0001`.
- Hold: N=4, `i_req=4'b0100` for one cycle and `i_ack=0` for 4 cycles, then drop `i_req`. Required: `o_sel=4'b0100` and `o_idx=2` constant throughout. After `i_ack=1`, the next cycle shows `o_vld=0`.
- Fairness: `i_req=4'b1111` with `i_ack=1` every cycle. Required grant sequence: `0001, 0010, 0100, 1000, 0001`, with no idle cycles.
- Pointer wrap/skip: ack a grant to index 2, then `i_req=4'b0101`. The next grant is `4'b0001` (scan 3 then 0), and the following one is `4'b0100`.
- Sole requester re-grant: `i_req=4'b0010` held and acked every cycle. Required: `o_sel=4'b0010` on consecutive cycles, never zero.
- Reset mid-grant: grant to index 3 active and `rst=1` for one cycle with `i_req=4'b1001`. Required: outputs zero after reset, then the next grant is `4'b0001` (`ptr` restored to 0).
